des_subkey_cache: RTL and testbench

Sits directly downstream of the branch key generator. On a load request it sequences the generator through key IDs 1..16 using the generator's start/ready handshake. It stores the 16 resulting 48-bit round keys in a local register file. It then serves them to the DES round datapath through a single-cycle read port, in encryption order or in reversed decryption order.

---
 rtl/des_subkey_cache.sv | 171 +++++++++++++++++
 tb/tb_des_subkey_cache.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_subkey_cache.sv
// DES round-key cache: walks the key generator through IDs 1..16 over a
// level start/ready handshake, stores the 48-bit subkeys, and serves them by round.
module des_subkey_cache #(
    parameter int unsigned TIMEOUT_CYCLES = 255   // must be >= 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] key_in,
    output logic        gen_start,
    output logic [5:0]  gen_keyid,
    output logic [63:0] gen_key,
    input  logic [47:0] gen_branchkey,
    input  logic        gen_ready,
    input  logic        rd_decrypt,
    input  logic [3:0]  rd_round,
    output logic [47:0] rd_subkey,
    output logic        busy,
    output logic        keys_valid,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        RELEASE,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [47:0]      slots [16];

    logic accept;
    logic capture;
    logic advance;
    logic finish;
    logic timeout;

    logic [3:0] wr_slot;
    logic [3:0] rd_slot;

    assign wr_slot = 4'(gen_keyid - 6'd1);
    assign rd_slot = rd_decrypt ? (4'd15 - rd_round) : rd_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples the pre-edge values regardless of block ordering.
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // wait_cnt==0 marks the first REQ cycle; a ready left over from
                // the previous key must not be mistaken for this one.
                if (gen_ready && (wait_cnt != '0)) begin
                    capture = 1'b1;
                    state_d = CAPTURE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!gen_ready) begin
                    if (gen_keyid == 6'd16) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = REQ;
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_start  <= 1'b0;
            gen_keyid  <= '0;
            gen_key    <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            rd_subkey  <= '0;
        end else begin
            // Registered decode of the next state keeps gen_start glitch-free.
            gen_start <= (state_d == REQ);

            if (state_d != state) begin
                wait_cnt <= '0;
            end else if ((state == REQ) || (state == RELEASE)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (accept) begin
                gen_key    <= key_in;
                gen_keyid  <= 6'd1;
                keys_valid <= 1'b0;
                err        <= 1'b0;
                busy       <= 1'b1;
            end
            if (advance) begin
                gen_keyid <= gen_keyid + 6'd1;
            end
            if (finish) begin
                keys_valid <= 1'b1;
                busy       <= 1'b0;
            end
            if (timeout) begin
                err        <= 1'b1;
                busy       <= 1'b0;
                keys_valid <= 1'b0;
            end

            // A load accepted this cycle invalidates the cache for this read too.
            if (keys_valid && !accept) begin
                rd_subkey <= slots[rd_slot];
            end else begin
                rd_subkey <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the key file is cleared on reset so no stale key material
            // from a previous session survives a reset.
            for (int i = 0; i < 16; i++) begin
                slots[i] <= '0;
            end
        end else if (capture) begin
            slots[wr_slot] <= gen_branchkey;
        end
    end

endmodule

// File: tb/tb_des_subkey_cache.sv
// Bench for des_subkey_cache: a behavioural DES key-schedule generator answers
// the handshake, and a read scoreboard checks the served subkeys.
module tb_des_subkey_cache;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [63:0] key_in;
    logic        gen_start;
    logic [5:0]  gen_keyid;
    logic [63:0] gen_key;
    logic [47:0] gen_branchkey;
    logic        gen_ready;
    logic        rd_decrypt;
    logic [3:0]  rd_round;
    logic [47:0] rd_subkey;
    logic        busy;
    logic        keys_valid;
    logic        err;

    int total = 0;
    int bad   = 0;

    bit          gen_real = 1'b1;
    logic [5:0]  start_ids [$];
    logic [47:0] sb [$];
    logic [47:0] kref [16];

    localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;

    des_subkey_cache #(.TIMEOUT_CYCLES(40)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .key_in       (key_in),
        .gen_start    (gen_start),
        .gen_keyid    (gen_keyid),
        .gen_key      (gen_key),
        .gen_branchkey(gen_branchkey),
        .gen_ready    (gen_ready),
        .rd_decrypt   (rd_decrypt),
        .rd_round     (rd_round),
        .rd_subkey    (rd_subkey),
        .busy         (busy),
        .keys_valid   (keys_valid),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DES key schedule: PC-1, per-round left rotations, PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
        int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                         10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                         63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                         14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
        int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                         23,19,12,4,26,8, 16,7,27,20,13,2,
                         41,52,31,37,47,55, 30,40,51,45,33,48,
                         44,49,39,56,34,53, 46,42,50,36,29,32};
        int sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - pc1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < n; r++) begin
            for (int s = 0; s < sh[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - pc2[i])];
        return k;
    endfunction

    task automatic set_ref(input logic [63:0] key);
        for (int r = 0; r < 16; r++) kref[r] = ref_subkey(key, r + 1);
    endtask

    // Generator model: answers a raised start after a keyid-dependent latency,
    // drops ready once start falls. In stub mode it never answers.
    initial begin
        int lat;
        lat = 0;
        gen_ready = 1'b0;
        gen_branchkey = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !gen_real) begin
                gen_ready = 1'b0;
                lat = 0;
            end else if (gen_start && !gen_ready) begin
                if (lat >= int'(gen_keyid % 6'd3)) begin
                    gen_branchkey = ref_subkey(gen_key, int'(gen_keyid));
                    gen_ready = 1'b1;
                    lat = 0;
                end else begin
                    lat++;
                end
            end else if (!gen_start && gen_ready) begin
                gen_ready = 1'b0;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_start && !prev) start_ids.push_back(gen_keyid);
            prev = gen_start;
        end
    end

    task automatic load_key(input logic [63:0] key);
        key_in = key;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load = 1'b0;
        key_in = '0;
        rd_decrypt = 1'b0;
        rd_round = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({gen_start, gen_keyid, gen_key, rd_subkey, busy, keys_valid, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: start=%b id=%0d key=%h sub=%h busy=%b valid=%b err=%b required all zero",
                     gen_start, gen_keyid, gen_key, rd_subkey, busy, keys_valid, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_build;
        int waited;
        int seq_bad;
        start_ids.delete();
        set_ref(KEY_A);
        load_key(KEY_A);
        total++;
        if (busy !== 1'b1 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL build_start: busy=%b keys_valid=%b required busy=1 keys_valid=0", busy, keys_valid);
        end
        repeat (8) @(negedge clk);
        load_key(64'hFFFF_FFFF_FFFF_FFFF);
        waited = 0;
        while (!keys_valid && !err && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (keys_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL build_done: keys_valid=%b busy=%b required 1/0 after %0d cycles", keys_valid, busy, waited);
        end
        total++;
        if (gen_key !== KEY_A) begin
            bad++;
            $display("FAIL load_while_busy: gen_key=%h required %h", gen_key, KEY_A);
        end
        seq_bad = (start_ids.size() != 16) ? 1 : 0;
        for (int i = 0; i < start_ids.size() && i < 16; i++) begin
            if (start_ids[i] !== 6'(i + 1)) seq_bad = 1;
        end
        total++;
        if (seq_bad != 0) begin
            bad++;
            $display("FAIL keyid_sequence: %0d start pulses, first id %0d; required 16 pulses with ids 1..16",
                     start_ids.size(), (start_ids.size() > 0) ? start_ids[0] : 6'd0);
        end
    endtask

    task automatic test_read_known;
        bit          dec_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  rnd_t [4] = '{4'd0, 4'd15, 4'd0, 4'd15};
        logic [47:0] exp_t [4] = '{48'h1B02EFFC7072, 48'hCB3D8B0E17F5,
                                   48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        logic [47:0] exp;
        for (int i = 0; i <= 4; i++) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                total++;
                if (rd_subkey !== exp) begin
                    bad++;
                    $display("FAIL read_known_%0d: rd_subkey=%h required %h", i - 1, rd_subkey, exp);
                end
            end
            if (i < 4) begin
                rd_decrypt = dec_t[i];
                rd_round = rnd_t[i];
                sb.push_back(exp_t[i]);
            end
            @(negedge clk);
        end
    endtask

    // Back-to-back sweep of all 32 (direction, round) reads against the model.
    task automatic test_read_sweep(input string tag);
        logic [47:0] exp;
        int r;
        for (int i = 0; i <= 32; i++) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                total++;
                if (rd_subkey !== exp) begin
                    bad++;
                    $display("FAIL sweep_%s_%0d: rd_subkey=%h required %h", tag, i - 1, rd_subkey, exp);
                end
            end
            if (i < 32) begin
                r = i % 16;
                rd_decrypt = (i >= 16);
                rd_round = 4'(r);
                sb.push_back(keys_valid ? ((i >= 16) ? kref[15 - r] : kref[r]) : 48'h0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reload_zero;
        logic [47:0] exp;
        int waited;
        rd_decrypt = 1'b0;
        rd_round = 4'd0;
        key_in = '0;
        load = 1'b1;
        sb.push_back(48'h0);
        @(negedge clk);
        load = 1'b0;
        exp = sb.pop_front();
        total++;
        if (rd_subkey !== exp) begin
            bad++;
            $display("FAIL read_same_cycle_as_load: rd_subkey=%h required %h", rd_subkey, exp);
        end
        total++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_invalidate: keys_valid=%b busy=%b required 0/1", keys_valid, busy);
        end
        set_ref(64'h0);
        test_read_sweep("rebuilding");
        waited = 0;
        while (!keys_valid && !err && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (keys_valid !== 1'b1) begin
            bad++;
            $display("FAIL rebuild_done: keys_valid=%b required 1", keys_valid);
        end
        test_read_sweep("zero_key");
    endtask

    task automatic test_timeout;
        int high;
        int waited;
        gen_real = 1'b0;
        load_key(KEY_A);
        high = 0;
        for (int i = 0; i < 200; i++) begin
            if (gen_start) high++;
            if (err) break;
            @(negedge clk);
        end
        total++;
        if (err !== 1'b1 || high != 40) begin
            bad++;
            $display("FAIL timeout_err: err=%b after %0d REQ cycles, required err=1 after 40", err, high);
        end
        total++;
        if (gen_start !== 1'b0 || busy !== 1'b0 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_outputs: start=%b busy=%b valid=%b required 0/0/0", gen_start, busy, keys_valid);
        end
        gen_real = 1'b1;
        load_key(KEY_A);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_cleared_by_load: err=%b busy=%b required 0/1", err, busy);
        end
        waited = 0;
        while (!keys_valid && !err && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (keys_valid !== 1'b1) begin
            bad++;
            $display("FAIL build_after_timeout: keys_valid=%b required 1", keys_valid);
        end
    endtask

    task automatic test_reset_midbuild;
        int waited;
        load_key(KEY_A);
        waited = 0;
        while (!(gen_start && gen_keyid == 6'd7) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (gen_keyid !== 6'd7 || gen_start !== 1'b1) begin
            bad++;
            $display("FAIL reach_key7: gen_keyid=%0d gen_start=%b required 7/1", gen_keyid, gen_start);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gen_start, gen_keyid, gen_key, rd_subkey, busy, keys_valid, err} !== '0) begin
            bad++;
            $display("FAIL async_reset: start=%b id=%0d key=%h sub=%h busy=%b valid=%b err=%b required all zero",
                     gen_start, gen_keyid, gen_key, rd_subkey, busy, keys_valid, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_ids.delete();
        set_ref(KEY_A);
        load_key(KEY_A);
        waited = 0;
        while (!keys_valid && !err && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (keys_valid !== 1'b1 || start_ids.size() != 16 || start_ids[0] !== 6'd1) begin
            bad++;
            $display("FAIL restart_after_reset: valid=%b pulses=%0d first id=%0d required 1/16/1",
                     keys_valid, start_ids.size(), (start_ids.size() > 0) ? start_ids[0] : 6'd0);
        end
        test_read_sweep("after_reset");
    endtask

    initial begin
        test_reset();
        test_build();
        test_read_known();
        test_read_sweep("key_a");
        test_reload_zero();
        test_timeout();
        test_reset_midbuild();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
